// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered output slot, valid/ready on both sides.
// Build option DECODE_SKID_EN inserts a 2-entry skid buffer between the decoder and the output slot.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_instr_id,
    output logic [4:0]  out_rs1_addr,
    output logic [4:0]  out_rs2_addr,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_illegal
);
    // Bundle layout: {id, rs1, rs2, rd, imm, pc, illegal}
    localparam int unsigned BW = 86;

    // INSTR_* codes, kept identical to instr_defines.vh
    localparam logic [5:0] INSTR_NONE = 6'd0, INSTR_LUI = 6'd1, INSTR_AUIPC = 6'd2, INSTR_JAL = 6'd3;
    localparam logic [5:0] INSTR_JALR = 6'd4, INSTR_BEQ = 6'd5, INSTR_BNE = 6'd6, INSTR_BLT = 6'd7;
    localparam logic [5:0] INSTR_BGE = 6'd8, INSTR_BLTU = 6'd9, INSTR_BGEU = 6'd10, INSTR_LB = 6'd11;
    localparam logic [5:0] INSTR_LH = 6'd12, INSTR_LW = 6'd13, INSTR_LBU = 6'd14, INSTR_LHU = 6'd15;
    localparam logic [5:0] INSTR_SB = 6'd16, INSTR_SH = 6'd17, INSTR_SW = 6'd18, INSTR_ADDI = 6'd19;
    localparam logic [5:0] INSTR_SLTI = 6'd20, INSTR_SLTIU = 6'd21, INSTR_XORI = 6'd22, INSTR_ORI = 6'd23;
    localparam logic [5:0] INSTR_ANDI = 6'd24, INSTR_SLLI = 6'd25, INSTR_SRLI = 6'd26, INSTR_SRAI = 6'd27;
    localparam logic [5:0] INSTR_ADD = 6'd28, INSTR_SUB = 6'd29, INSTR_SLL = 6'd30, INSTR_SLT = 6'd31;
    localparam logic [5:0] INSTR_SLTU = 6'd32, INSTR_XOR = 6'd33, INSTR_SRL = 6'd34, INSTR_SRA = 6'd35;
    localparam logic [5:0] INSTR_OR = 6'd36, INSTR_AND = 6'd37, INSTR_FENCE = 6'd38, INSTR_ECALL = 6'd39;
    localparam logic [5:0] INSTR_EBREAK = 6'd40;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [BW-1:0] BUNDLE_CLR = {53'b0, RESET_PC, 1'b0};

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_raw;
    logic        use_rs1, use_rs2, use_rd;
    logic [5:0]  dec_id;
    logic        dec_illegal;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic [BW-1:0] bundle_d, slot_data;
    logic        slot_free, push_in, slot_load;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_sh = {27'b0, in_instr[24:20]};

    // Opcode/funct decode; anything left at INSTR_NONE is illegal
    always_comb begin
        dec_id  = INSTR_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm_raw = '0;
        case (opcode)
            OP_LUI:   begin dec_id = INSTR_LUI;   use_rd = 1'b1; imm_raw = imm_u; end
            OP_AUIPC: begin dec_id = INSTR_AUIPC; use_rd = 1'b1; imm_raw = imm_u; end
            OP_JAL:   begin dec_id = INSTR_JAL;   use_rd = 1'b1; imm_raw = imm_j; end
            OP_JALR: begin
                if (funct3 == 3'd0) dec_id = INSTR_JALR;
                use_rd = 1'b1; use_rs1 = 1'b1; imm_raw = imm_i;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'd0: dec_id = INSTR_BEQ;
                    3'd1: dec_id = INSTR_BNE;
                    3'd4: dec_id = INSTR_BLT;
                    3'd5: dec_id = INSTR_BGE;
                    3'd6: dec_id = INSTR_BLTU;
                    3'd7: dec_id = INSTR_BGEU;
                    default: dec_id = INSTR_NONE;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_raw = imm_b;
            end
            OP_LOAD: begin
                case (funct3)
                    3'd0: dec_id = INSTR_LB;
                    3'd1: dec_id = INSTR_LH;
                    3'd2: dec_id = INSTR_LW;
                    3'd4: dec_id = INSTR_LBU;
                    3'd5: dec_id = INSTR_LHU;
                    default: dec_id = INSTR_NONE;
                endcase
                use_rd = 1'b1; use_rs1 = 1'b1; imm_raw = imm_i;
            end
            OP_STORE: begin
                case (funct3)
                    3'd0: dec_id = INSTR_SB;
                    3'd1: dec_id = INSTR_SH;
                    3'd2: dec_id = INSTR_SW;
                    default: dec_id = INSTR_NONE;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm_raw = imm_s;
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; imm_raw = imm_i;
                case (funct3)
                    3'd0: dec_id = INSTR_ADDI;
                    3'd2: dec_id = INSTR_SLTI;
                    3'd3: dec_id = INSTR_SLTIU;
                    3'd4: dec_id = INSTR_XORI;
                    3'd6: dec_id = INSTR_ORI;
                    3'd7: dec_id = INSTR_ANDI;
                    3'd1: begin
                        imm_raw = imm_sh;
                        if (funct7 == 7'd0) dec_id = INSTR_SLLI;
                    end
                    default: begin
                        imm_raw = imm_sh;
                        if (funct7 == 7'd0)        dec_id = INSTR_SRLI;
                        else if (funct7 == F7_ALT) dec_id = INSTR_SRAI;
                    end
                endcase
            end
            OP_REG: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (funct7 == 7'd0) begin
                    case (funct3)
                        3'd0: dec_id = INSTR_ADD;
                        3'd1: dec_id = INSTR_SLL;
                        3'd2: dec_id = INSTR_SLT;
                        3'd3: dec_id = INSTR_SLTU;
                        3'd4: dec_id = INSTR_XOR;
                        3'd5: dec_id = INSTR_SRL;
                        3'd6: dec_id = INSTR_OR;
                        default: dec_id = INSTR_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd0)      dec_id = INSTR_SUB;
                    else if (funct3 == 3'd5) dec_id = INSTR_SRA;
                end
            end
            // FENCE/ECALL/EBREAK carry no operands for EX; fields stay zero
            OP_FENCE:  if (funct3 == 3'd0) dec_id = INSTR_FENCE;
            OP_SYSTEM: begin
                if (in_instr == 32'h0000_0073)      dec_id = INSTR_ECALL;
                else if (in_instr == 32'h0010_0073) dec_id = INSTR_EBREAK;
            end
            default: dec_id = INSTR_NONE;
        endcase
    end

    assign dec_illegal = (dec_id == INSTR_NONE);
    assign dec_rs1  = (use_rs1 && !dec_illegal) ? in_instr[19:15] : 5'd0;
    assign dec_rs2  = (use_rs2 && !dec_illegal) ? in_instr[24:20] : 5'd0;
    assign dec_rd   = (use_rd  && !dec_illegal) ? in_instr[11:7]  : 5'd0;
    assign dec_imm  = dec_illegal ? 32'd0 : imm_raw;
    assign bundle_d = {dec_id, dec_rs1, dec_rs2, dec_rd, dec_imm, in_pc, dec_illegal};

    assign slot_free = !out_valid || out_ready;
    assign push_in   = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
    logic [BW-1:0] skid_q [2];
    logic [BW-1:0] skid_n [2];
    logic [1:0]    skid_cnt, cnt_n;
    logic          skid_full;

    // Skid head feeds the slot before any new word, preserving order
    always_comb begin
        skid_n    = skid_q;
        cnt_n     = skid_cnt;
        slot_load = 1'b0;
        slot_data = bundle_d;
        if (flush) begin
            cnt_n = 2'd0;
        end else begin
            if (slot_free && skid_cnt != 2'd0) begin
                slot_load = 1'b1;
                slot_data = skid_q[0];
                skid_n[0] = skid_q[1];
                cnt_n     = skid_cnt - 2'd1;
            end
            if (push_in) begin
                if (slot_free && skid_cnt == 2'd0) begin
                    slot_load = 1'b1;
                    slot_data = bundle_d;
                end else begin
                    skid_n[cnt_n[0]] = bundle_d;
                    cnt_n = cnt_n + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            skid_cnt  <= 2'd0;
            skid_full <= 1'b0;
        end else begin
            skid_q[0] <= skid_n[0];
            skid_q[1] <= skid_n[1];
            skid_cnt  <= cnt_n;
            skid_full <= (cnt_n == 2'd2);
        end
    end

    assign in_ready = !skid_full;
`else
    assign in_ready  = slot_free;
    assign slot_load = push_in;
    assign slot_data = bundle_d;
`endif

    // Output slot; an emptied slot returns to the reset bundle so no stale fields linger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            {out_instr_id, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm, out_pc, out_illegal} <= BUNDLE_CLR;
        end else if (flush || (!slot_load && out_ready)) begin
            out_valid <= 1'b0;
            {out_instr_id, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm, out_pc, out_illegal} <= BUNDLE_CLR;
        end else if (slot_load) begin
            out_valid <= 1'b1;
            {out_instr_id, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm, out_pc, out_illegal} <= slot_data;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of known encodings, stall/flush/reset sequences, random legal streams.
module tb_decode_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int NV = 18;
    localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6, F_SYS = 7;

    typedef struct packed {
        logic [5:0]  id;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_illegal;
    logic [5:0]  out_instr_id;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [31:0] out_imm, out_pc;

    exp_t   sb[$];
    exp_t   cur_exp;
    exp_t   held;
    vec_t   tbl [NV];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    logic   accepted = 1'b0;
    logic   rand_ready = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_0100;

    decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr_id(out_instr_id),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] w, input int id, input int rs1, input int rs2,
                                input int rd, input logic [31:0] imm, input logic ill);
        vec_t v;
        v.instr = w;
        v.e.id = 6'(id); v.e.rs1 = 5'(rs1); v.e.rs2 = 5'(rs2); v.e.rd = 5'(rd);
        v.e.imm = imm; v.e.pc = 32'd0; v.e.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One cycle: sample at negedge (scoreboard pop then push), return at posedge+1
    task automatic tick();
        exp_t got;
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                got.id = out_instr_id; got.rs1 = out_rs1_addr; got.rs2 = out_rs2_addr;
                got.rd = out_rd_addr; got.imm = out_imm; got.pc = out_pc; got.ill = out_illegal;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_bundle: got id=%0d pc=%h, required no bundle", got.id, got.pc);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL bundle: got id=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h ill=%0b, required id=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h ill=%0b",
                                 got.id, got.rs1, got.rs2, got.rd, got.imm, got.pc, got.ill,
                                 e.id, e.rs1, e.rs2, e.rd, e.imm, e.pc, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic prepare(input logic [31:0] w, input exp_t e);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc_ctr;
        cur_exp  = e;
        cur_exp.pc = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        tests++;
        if (!accepted) begin
            fails++;
            $display("FAIL handshake_timeout: not accepted after %0d cycles, required acceptance", n);
        end
    endtask

    task automatic send(input logic [31:0] w, input exp_t e);
        prepare(w, e);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (sb.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL drain: %0d bundles still expected, out_valid=%0b, required 0 and 0", sb.size(), out_valid);
        end
    endtask

    // Build a random legal word from its fields; expectation comes from the chosen fields
    task automatic gen(output logic [31:0] w, output exp_t e);
        int id, fmt;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] r;
        logic [12:0] ib;
        logic [20:0] ij;
        id = int'($urandom_range(1, 40));
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); r = $urandom;
        f3 = 3'd0; f7 = 7'd0; op = 7'd0; fmt = F_SYS; w = 32'd0;
        e = '0;
        e.id = 6'(id);
        case (id)
            1:  begin fmt = F_U; op = 7'h37; end
            2:  begin fmt = F_U; op = 7'h17; end
            3:  begin fmt = F_J; op = 7'h6F; end
            4:  begin fmt = F_I; op = 7'h67; end
            5, 6:  begin fmt = F_B; op = 7'h63; f3 = 3'(id - 5); end
            7, 8, 9, 10: begin fmt = F_B; op = 7'h63; f3 = 3'(id - 3); end
            11, 12, 13: begin fmt = F_I; op = 7'h03; f3 = 3'(id - 11); end
            14, 15: begin fmt = F_I; op = 7'h03; f3 = 3'(id - 10); end
            16, 17, 18: begin fmt = F_S; op = 7'h23; f3 = 3'(id - 16); end
            19: begin fmt = F_I; op = 7'h13; f3 = 3'd0; end
            20, 21, 22: begin fmt = F_I; op = 7'h13; f3 = 3'(id - 18); end
            23, 24: begin fmt = F_I; op = 7'h13; f3 = 3'(id - 17); end
            25: begin fmt = F_SH; op = 7'h13; f3 = 3'd1; end
            26: begin fmt = F_SH; op = 7'h13; f3 = 3'd5; end
            27: begin fmt = F_SH; op = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            28: begin fmt = F_R; op = 7'h33; f3 = 3'd0; end
            29: begin fmt = F_R; op = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            30, 31, 32, 33, 34: begin fmt = F_R; op = 7'h33; f3 = 3'(id - 29); end
            35: begin fmt = F_R; op = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            36, 37: begin fmt = F_R; op = 7'h33; f3 = 3'(id - 30); end
            38: w = 32'h0FF0_000F;
            39: w = 32'h0000_0073;
            default: w = 32'h0010_0073;
        endcase
        case (fmt)
            F_R:  begin w = {f7, rs2, rs1, f3, rd, op}; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; end
            F_I:  begin w = {r[11:0], rs1, f3, rd, op}; e.rs1 = rs1; e.rd = rd;
                        e.imm = {{20{r[11]}}, r[11:0]}; end
            F_SH: begin w = {f7, r[4:0], rs1, f3, rd, op}; e.rs1 = rs1; e.rd = rd;
                        e.imm = {27'd0, r[4:0]}; end
            F_S:  begin w = {r[11:5], rs2, rs1, f3, r[4:0], op}; e.rs1 = rs1; e.rs2 = rs2;
                        e.imm = {{20{r[11]}}, r[11:0]}; end
            F_B:  begin ib = {r[12:1], 1'b0};
                        w = {ib[12], ib[10:5], rs2, rs1, f3, ib[4:1], ib[11], op};
                        e.rs1 = rs1; e.rs2 = rs2; e.imm = {{19{ib[12]}}, ib}; end
            F_U:  begin w = {r[31:12], rd, op}; e.rd = rd; e.imm = {r[31:12], 12'd0}; end
            F_J:  begin ij = {r[20:1], 1'b0};
                        w = {ij[20], ij[10:1], ij[11], ij[19:12], rd, op};
                        e.rd = rd; e.imm = {{11{ij[20]}}, ij}; end
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] w;
        exp_t e;
        int c0;

        tbl[0]  = mk(32'hFFF0_0093, 19, 0, 0, 1, 32'hFFFF_FFFF, 1'b0);
        tbl[1]  = mk(32'h4030_D113, 27, 1, 0, 2, 32'h0000_0003, 1'b0);
        tbl[2]  = mk(32'h4020_81B3, 29, 1, 2, 3, 32'h0000_0000, 1'b0);
        tbl[3]  = mk(32'hFE20_8EE3,  5, 1, 2, 0, 32'hFFFF_FFFC, 1'b0);
        tbl[4]  = mk(32'h1234_52B7,  1, 0, 0, 5, 32'h1234_5000, 1'b0);
        tbl[5]  = mk(32'h0000_0000,  0, 0, 0, 0, 32'h0000_0000, 1'b1);
        tbl[6]  = mk(32'h0200_D093,  0, 0, 0, 0, 32'h0000_0000, 1'b1);
        tbl[7]  = mk(32'h0080_00EF,  3, 0, 0, 1, 32'h0000_0008, 1'b0);
        tbl[8]  = mk(32'h0020_A623, 18, 1, 2, 0, 32'h0000_000C, 1'b0);
        tbl[9]  = mk(32'hFF82_2183, 13, 4, 0, 3, 32'hFFFF_FFF8, 1'b0);
        tbl[10] = mk(32'h0FF0_000F, 38, 0, 0, 0, 32'h0000_0000, 1'b0);
        tbl[11] = mk(32'h0000_0073, 39, 0, 0, 0, 32'h0000_0000, 1'b0);
        tbl[12] = mk(32'h0010_0073, 40, 0, 0, 0, 32'h0000_0000, 1'b0);
        tbl[13] = mk(32'h0000_0010,  0, 0, 0, 0, 32'h0000_0000, 1'b1);
        tbl[14] = mk(32'h4020_9093,  0, 0, 0, 0, 32'h0000_0000, 1'b1);
        tbl[15] = mk(32'hFFFF_F097,  2, 0, 0, 1, 32'hFFFF_F000, 1'b0);
        tbl[16] = mk(32'h0030_D093, 26, 1, 0, 1, 32'h0000_0003, 1'b0);
        tbl[17] = mk(32'h0220_80B3,  0, 0, 0, 0, 32'h0000_0000, 1'b1);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("reset_valid",   32'(out_valid), 32'd0);
        chk("reset_pc",      out_pc, RESET_PC);
        chk("reset_id",      32'(out_instr_id), 32'd0);
        chk("reset_imm",     out_imm, 32'd0);
        chk("reset_illegal", 32'(out_illegal), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Table vectors, one at a time, checking 1-cycle latency
        for (int i = 0; i < NV; i++) begin
            send(tbl[i].instr, tbl[i].e);
            in_valid = 1'b0;
            chk("latency_valid", 32'(out_valid), 32'd1);
            tick();
        end
        drain();

        // Stall: out_ready low for 5 cycles with a second word waiting
        out_ready = 1'b0;
        gen(w, e);
        send(w, e);
        held = cur_exp;
        gen(w, e);
        prepare(w, e);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_id",    32'(out_instr_id), 32'(held.id));
            chk("stall_imm",   out_imm, held.imm);
            chk("stall_pc",    out_pc, held.pc);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_id",    32'(out_instr_id), 32'(cur_exp.id));
        chk("release_pc",    out_pc, cur_exp.pc);
        drain();

        // Flush with a held bundle and an input in the same cycle
        out_ready = 1'b0;
        gen(w, e);
        send(w, e);
        gen(w, e);
        prepare(w, e);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // Flush wins over out_ready; in_ready stays up
        gen(w, e);
        send(w, e);
        gen(w, e);
        prepare(w, e);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_ready_valid", 32'(out_valid), 32'd0);
        drain();

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        gen(w, e);
        send(w, e);
        gen(w, e);
        prepare(w, e);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(out_valid), 32'd0);
        chk("midreset_pc",    out_pc, RESET_PC);
        chk("midreset_id",    32'(out_instr_id), 32'd0);
        chk("midreset_imm",   out_imm, 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_reset_valid", 32'(out_valid), 32'd0);

        // 100 random legal words at full rate
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            gen(w, e);
            send(w, e);
        end
        chk("full_rate_cycles", 32'(cyc - c0), 32'd100);
        drain();

        // Random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            gen(w, e);
            send(w, e);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
